wb_test_slave: RTL and testbench

- Wishbone classic slave with an internal memory; it terminates the bus cycles generated by the team's randomised Wishbone test masters in interconnect simulations.
- Decodes one address region and stores writes with byte-lane granularity.
- Returns read data after an LFSR-driven pseudo-random number of wait states.
- Counts completed and aborted transfers and flags when the test quota has been met.

---
 rtl/wb_test_slave.sv | 142 ++++++++++++++
 tb/tb_wb_test_slave.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_test_slave.sv
// Wishbone classic test slave: byte-lane memory behind one address region, LFSR-driven
// random wait states, and saturating completed/aborted transfer counters with a quota flag.
module wb_test_slave #(
    parameter logic [1:0]  REGION    = 2'd0,
    parameter int          AW        = 8,
    parameter int          WAIT_BITS = 2,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          NREADS    = 10,
    parameter int          NWRITES   = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] dat_w,
    output logic [31:0] dat_r,
    input  logic [31:0] adr,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic        cyc,
    input  logic        stb,
    output logic        ack,
    output logic [15:0] rcount,
    output logic [15:0] wcount,
    output logic [15:0] aborts,
    output logic        tend
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     wcnt_reg, wcnt_next;
    logic [15:0]    lfsr_reg;
    logic [AW-1:0]  idx_reg;
    logic           we_reg;
    logic [3:0]     sel_reg;
    logic [31:0]    wdat_reg;
    logic [15:0]    rcount_reg, wcount_reg, aborts_reg;
    logic           tend_reg;
    logic           req, hit, accept, abort;
    logic [3:0]     draw;
    logic [AW-1:0]  rd_addr;
    logic           unused_adr_bits;

    assign req    = cyc & stb;
    assign hit    = req & (adr[31:30] == REGION);
    assign accept = (state_reg == IDLE) & hit;
    assign abort  = (state_reg == WAIT) & ~req;
    assign unused_adr_bits = ^adr[29:AW];

    generate
        if (WAIT_BITS == 0) begin : g_nowait
            assign draw = 4'd0;
        end else begin : g_wait
            assign draw = 4'(lfsr_reg[WAIT_BITS-1:0]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        case (state_reg)
            IDLE: begin
                if (hit) begin
                    wcnt_next  = draw;
                    state_next = (draw == 4'd0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                // wcnt counts the wait cycles still owed, including this one
                if (!req)
                    state_next = IDLE;
                else if (wcnt_reg <= 4'd1)
                    state_next = ACK;
                else
                    wcnt_next = wcnt_reg - 4'd1;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg  <= IDLE;
            wcnt_reg   <= 4'd0;
            lfsr_reg   <= SEED;
            idx_reg    <= '0;
            we_reg     <= 1'b0;
            sel_reg    <= 4'd0;
            wdat_reg   <= 32'd0;
            rcount_reg <= 16'd0;
            wcount_reg <= 16'd0;
            aborts_reg <= 16'd0;
            tend_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            lfsr_reg  <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
            if (accept) begin
                idx_reg  <= adr[AW-1:0];
                we_reg   <= we;
                sel_reg  <= sel;
                wdat_reg <= dat_w;
            end
            if (state_reg == ACK) begin
                if (we_reg) begin
                    if (wcount_reg != 16'hFFFF) wcount_reg <= wcount_reg + 16'd1;
                end else begin
                    if (rcount_reg != 16'hFFFF) rcount_reg <= rcount_reg + 16'd1;
                end
            end
            if (abort && aborts_reg != 16'hFFFF)
                aborts_reg <= aborts_reg + 16'd1;
            tend_reg <= tend_reg | ((rcount_reg >= 16'(NREADS)) && (wcount_reg >= 16'(NWRITES)));
        end
    end

    // Read the incoming index at acceptance so zero-wait reads have data in the ACK cycle
    assign rd_addr = (state_reg == IDLE) ? adr[AW-1:0] : idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [2**AW];
            logic [7:0] rd_byte;

            always_ff @(posedge sys_clk) begin
                if (state_reg == ACK && we_reg && sel_reg[gi])
                    mem[idx_reg] <= wdat_reg[8*gi +: 8];
                rd_byte <= mem[rd_addr];
            end

            assign dat_r[8*gi +: 8] = (state_reg == ACK && !we_reg) ? rd_byte : 8'd0;
        end
    endgenerate

    assign ack    = (state_reg == ACK);
    assign rcount = rcount_reg;
    assign wcount = wcount_reg;
    assign aborts = aborts_reg;
    assign tend   = tend_reg;

endmodule

// File: tb/tb_wb_test_slave.sv
// Directed bench for wb_test_slave: a zero-wait instance (REGION 0, quota 3/3) and a
// random-wait instance (REGION 1, WAIT_BITS 2) sharing the address/data bus.
module tb_wb_test_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dat_w, adr;
    logic        we;
    logic [3:0]  sel;
    logic        cyc0, stb0, cyc1, stb1;
    logic [31:0] dat_r0, dat_r1;
    logic        ack0, ack1, tend0, tend1;
    logic [15:0] rcount0, wcount0, aborts0, rcount1, wcount1, aborts1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_test_slave #(.REGION(2'd0), .AW(8), .WAIT_BITS(0), .SEED(16'hACE1), .NREADS(3), .NWRITES(3)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .dat_w(dat_w), .dat_r(dat_r0), .adr(adr), .we(we),
        .sel(sel), .cyc(cyc0), .stb(stb0), .ack(ack0), .rcount(rcount0), .wcount(wcount0),
        .aborts(aborts0), .tend(tend0)
    );

    wb_test_slave #(.REGION(2'd1), .AW(8), .WAIT_BITS(2), .SEED(16'hACE1), .NREADS(10), .NWRITES(10)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .dat_w(dat_w), .dat_r(dat_r1), .adr(adr), .we(we),
        .sel(sel), .cyc(cyc1), .stb(stb1), .ack(ack1), .rcount(rcount1), .wcount(wcount1),
        .aborts(aborts1), .tend(tend1)
    );

    // Reference LFSR x^16+x^14+x^13+x^11+1 for predicting dut1 wait states
    logic [15:0] mlfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mlfsr <= 16'hACE1;
        else        mlfsr <= {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int   ackn0 = 0, ackn1 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(negedge clk) begin
        if (ack0 === 1'b1) begin
            ackn0 <= ackn0 + 1;
            check("ack0_not_back_to_back", {31'd0, prev0}, 32'd0);
        end
        if (ack1 === 1'b1) begin
            ackn1 <= ackn1 + 1;
            check("ack1_not_back_to_back", {31'd0, prev1}, 32'd0);
        end
        prev0 <= (ack0 === 1'b1);
        prev1 <= (ack1 === 1'b1);
    end

    // One transfer; called and returning at 1 time unit after a rising edge
    task automatic xfer(input bit which, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat, output int draw);
        adr = a; dat_w = d; we = w; sel = s;
        draw = int'(mlfsr[1:0]);
        if (which) begin cyc1 = 1'b1; stb1 = 1'b1; end
        else       begin cyc0 = 1'b1; stb0 = 1'b1; end
        lat = 99;
        rd  = 32'd0;
        for (int k = 1; k <= 12 && lat == 99; k++) begin
            @(posedge clk); #1;
            if ((which ? ack1 : ack0) === 1'b1) begin
                lat = k;
                rd  = which ? dat_r1 : dat_r0;
            end
        end
        cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
        @(posedge clk); #1;
        $display("xfer dut%0d we=%0b adr=%h sel=%h dat_w=%h -> lat=%0d rd=%h", which, w, a, s, d, lat, rd);
    endtask

    logic [31:0] rd, pat, sh [8];
    logic [3:0]  sl;
    int          lat, draw, idx, a_before;
    bit          found;

    initial begin
        rst_n = 1'b0;
        cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
        adr = 32'd0; dat_w = 32'd0; we = 1'b0; sel = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_dat_r0", dat_r0, 32'd0);
        check("rst_rcount0", {16'd0, rcount0}, 32'd0);
        check("rst_wcount0", {16'd0, wcount0}, 32'd0);
        check("rst_tend0", {31'd0, tend0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        rst_n = 1'b1;

        // Region miss: region 2 address on the REGION=1 slave, held 20 cycles
        adr = 32'h8000_0002; we = 1'b0; sel = 4'hF; cyc1 = 1'b1; stb1 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("miss_acks", 32'(ackn1), 32'd0);
        check("miss_rcount", {16'd0, rcount1}, 32'd0);
        check("miss_wcount", {16'd0, wcount1}, 32'd0);
        check("miss_aborts", {16'd0, aborts1}, 32'd0);
        cyc1 = 1'b0; stb1 = 1'b0;
        @(posedge clk); #1;

        // Zero wait states: write then read back
        xfer(0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 4'hF, rd, lat, draw);
        check("w0_lat_write", 32'(lat), 32'd1);
        xfer(0, 1'b0, 32'h0000_0005, 32'h0, 4'hF, rd, lat, draw);
        check("w0_lat_read", 32'(lat), 32'd1);
        check("w0_read_data", rd, 32'hDEAD_BEEF);
        check("w0_wcount", {16'd0, wcount0}, 32'd1);
        check("w0_rcount", {16'd0, rcount0}, 32'd1);
        check("dat_r_idle_zero", dat_r0, 32'd0);

        // Byte lanes and quota
        xfer(0, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 4'hF, rd, lat, draw);
        xfer(0, 1'b0, 32'h0000_0005, 32'h0, 4'hF, rd, lat, draw);
        check("reread5", rd, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h0000_0003, 32'h0, 4'hF, rd, lat, draw);
        check("read3_full", rd, 32'hFFFF_FFFF);
        check("quota_rcount3", {16'd0, rcount0}, 32'd3);
        check("quota_tend_2w", {31'd0, tend0}, 32'd0);
        xfer(0, 1'b1, 32'h0000_0003, 32'h1234_5678, 4'b0101, rd, lat, draw);
        check("quota_wcount3", {16'd0, wcount0}, 32'd3);
        check("quota_tend_same_cycle", {31'd0, tend0}, 32'd0);
        @(posedge clk); #1;
        check("quota_tend_next", {31'd0, tend0}, 32'd1);
        xfer(0, 1'b0, 32'h0000_0003, 32'h0, 4'hF, rd, lat, draw);
        check("byte_lane_merge", rd, 32'hFF34_FF78);
        check("tend_sticky", {31'd0, tend0}, 32'd1);

        // Abort during wait states
        xfer(1, 1'b1, 32'h4000_0006, 32'hA5A5_0F0F, 4'hF, rd, lat, draw);
        check("abort_prior_lat", 32'(lat), 32'(draw + 1));
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            if (mlfsr[1:0] == 2'd3) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("abort_draw3_found", {31'd0, found}, 32'd1);
        a_before = ackn1;
        adr = 32'h4000_0006; dat_w = 32'h1111_1111; we = 1'b1; sel = 4'hF;
        cyc1 = 1'b1; stb1 = 1'b1;
        @(posedge clk); #1;
        cyc1 = 1'b0; stb1 = 1'b0;
        @(posedge clk); #1;
        check("abort_count", {16'd0, aborts1}, 32'd1);
        check("abort_no_ack", 32'(ackn1), 32'(a_before));
        check("abort_wcount", {16'd0, wcount1}, 32'd1);
        $display("abort dut1 adr=40000006 aborts=%0d", aborts1);
        xfer(1, 1'b0, 32'h4000_0006, 32'h0, 4'hF, rd, lat, draw);
        check("abort_keeps_old", rd, 32'hA5A5_0F0F);

        // Random latency and data over 50 transfers
        for (int i = 0; i < 50; i++) begin
            idx = i % 8;
            if (i < 8) begin
                pat = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
                xfer(1, 1'b1, 32'h4000_0000 | 32'(idx), pat, 4'hF, rd, lat, draw);
                sh[idx] = pat;
            end else if (i % 2 == 0) begin
                pat = 32'h9E37_79B9 * 32'(i);
                sl  = 4'(i);
                xfer(1, 1'b1, 32'h4000_0000 | 32'(idx), pat, sl, rd, lat, draw);
                for (int b = 0; b < 4; b++)
                    if (sl[b]) sh[idx][8*b +: 8] = pat[8*b +: 8];
            end else begin
                xfer(1, 1'b0, 32'h4000_0000 | 32'(idx), 32'h0, 4'hF, rd, lat, draw);
                check("rand_read_data", rd, sh[idx]);
            end
            check("rand_latency", 32'(lat), 32'(draw + 1));
        end

        // Asynchronous reset in the middle of an ack cycle
        adr = 32'h0000_0003; we = 1'b0; sel = 4'hF; cyc0 = 1'b1; stb0 = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_ack", {31'd0, ack0}, 32'd1);
        check("pre_reset_data", dat_r0, 32'hFF34_FF78);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ack", {31'd0, ack0}, 32'd0);
        check("async_rst_dat_r", dat_r0, 32'd0);
        check("async_rst_tend", {31'd0, tend0}, 32'd0);
        check("async_rst_rcount", {16'd0, rcount0}, 32'd0);
        check("async_rst_wcount", {16'd0, wcount0}, 32'd0);
        check("async_rst_aborts1", {16'd0, aborts1}, 32'd0);
        check("async_rst_wcount1", {16'd0, wcount1}, 32'd0);
        $display("async reset dut0 ack=%0b tend=%0b rcount=%0d wcount=%0d", ack0, tend0, rcount0, wcount0);
        cyc0 = 1'b0; stb0 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
